// File: rtl/hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Purpose: pipeline hazard unit combining EX-stage operand forwarding with a
// per-register latency scoreboard. The scoreboard holds one countdown per
// architectural register. A nonzero count means the register's result is
// not yet available. A decode-stage source that reads such a register raises
// stall, which holds IF/ID and inserts a bubble into EX.
//
// Optional feature: define HAZ_STATS_EN to add the stall_cycles output, a
// saturating 32-bit count of stalled cycles. Without the macro, neither the
// port nor the counter exists.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   flush         in   clears all scoreboard entries on the next edge
//   rs_ID         in   decode-stage sources, source i at [i*REG_AW +: REG_AW]
//   rs_ID_valid   in   per-source "operand used" flags
//   issue_valid   in   decode-stage instruction valid
//   issue_we      in   decode-stage instruction writes a register
//   issue_rd      in   decode-stage destination register
//   issue_lat     in   result latency in cycles (0 = forwarding covers it)
//   rs_EX         in   EX-stage sources, packed as rs_ID
//   rd_MEM/rd_WB  in   destination registers in MEM / WB
//   RegWrite_MEM/RegWrite_WB in   write enables in MEM / WB
//   forward       out  per-source select, source i at [2i+1:2i]
//                      (2'b10 = MEM, 2'b01 = WB, 2'b00 = register file)
//   stall         out  decode-stage hazard stall
//   stall_cycles  out  (HAZ_STATS_EN only) saturating stall-cycle count
// ---------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_SRC*REG_AW-1:0]   rs_ID,
  input  logic [NUM_SRC-1:0]          rs_ID_valid,
  input  logic                        issue_valid,
  input  logic                        issue_we,
  input  logic [REG_AW-1:0]           issue_rd,
  input  logic [LAT_W-1:0]            issue_lat,
  input  logic [NUM_SRC*REG_AW-1:0]   rs_EX,
  input  logic [REG_AW-1:0]           rd_MEM,
  input  logic [REG_AW-1:0]           rd_WB,
  input  logic                        RegWrite_MEM,
  input  logic                        RegWrite_WB,
  output logic [2*NUM_SRC-1:0]        forward,
  output logic                        stall
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);

  localparam int NUM_REG = 2**REG_AW;

  logic [LAT_W-1:0] w_cnt [NUM_REG];
  logic             w_accept;

  // -------------------------------------------------------------------------
  // Forwarding: purely combinational. MEM holds the younger result, so it
  // wins over WB. Register 0 is hard-wired zero and is never forwarded.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
      logic [REG_AW-1:0] w_src;
      logic              w_hit_mem;
      logic              w_hit_wb;

      assign w_src     = rs_EX[gi*REG_AW +: REG_AW];
      assign w_hit_mem = RegWrite_MEM && (rd_MEM != '0) && (rd_MEM == w_src);
      assign w_hit_wb  = RegWrite_WB  && (rd_WB  != '0) && (rd_WB  == w_src);
      assign forward[2*gi +: 2] = w_hit_mem ? 2'b10 :
                                  w_hit_wb  ? 2'b01 : 2'b00;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Stall: any used source whose scoreboard entry is still counting. The
  // lookup uses the current (pre-update) counts, so an instruction that
  // reads its own destination does not stall on itself.
  // -------------------------------------------------------------------------
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_ID_valid[i] && (w_cnt[rs_ID[i*REG_AW +: REG_AW]] != '0)) begin
        stall = 1'b1;
      end
    end
  end

  // A stalled instruction is not recorded; it is re-presented later.
  assign w_accept = issue_valid && issue_we && (issue_rd != '0) && !stall && !flush;

  // -------------------------------------------------------------------------
  // Scoreboard counters. Register 0 never holds an entry. Priority per
  // entry: flush, then a fresh issue load (overriding the decrement), then
  // saturating countdown. Loading issue_lat==0 leaves the entry idle.
  // -------------------------------------------------------------------------
  assign w_cnt[0] = '0;

  generate
    for (genvar gi = 1; gi < NUM_REG; gi++) begin : g_cnt
      logic [LAT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (flush) begin
          r_cnt <= '0;
        end else if (w_accept && (issue_rd == REG_AW'(gi))) begin
          r_cnt <= issue_lat;
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - LAT_W'(1);
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

`ifdef HAZ_STATS_EN
  // Stall statistics: counts cycles with stall high and sticks at all-ones.
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// Testbench for hazard_scoreboard_unit. The reference model tracks each
// register by the edge number at which its result becomes ready; a register
// is busy while the current edge count is below that number. Directed steps
// cover the corner cases, followed by a randomized run. Define HAZ_STATS_EN
// to also check stall_cycles.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

  localparam int NS = 2;
  localparam int AW = 5;
  localparam int LW = 3;
  localparam int NR = 2**AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [NS*AW-1:0]  rs_ID;
  logic [NS-1:0]     rs_ID_valid;
  logic              issue_valid;
  logic              issue_we;
  logic [AW-1:0]     issue_rd;
  logic [LW-1:0]     issue_lat;
  logic [NS*AW-1:0]  rs_EX;
  logic [AW-1:0]     rd_MEM;
  logic [AW-1:0]     rd_WB;
  logic              RegWrite_MEM;
  logic              RegWrite_WB;
  logic [2*NS-1:0]   forward;
  logic              stall;
`ifdef HAZ_STATS_EN
  logic [31:0]       stall_cycles;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .NUM_SRC (NS),
    .REG_AW  (AW),
    .LAT_W   (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .rs_ID        (rs_ID),
    .rs_ID_valid  (rs_ID_valid),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_rd     (issue_rd),
    .issue_lat    (issue_lat),
    .rs_EX        (rs_EX),
    .rd_MEM       (rd_MEM),
    .rd_WB        (rd_WB),
    .RegWrite_MEM (RegWrite_MEM),
    .RegWrite_WB  (RegWrite_WB),
    .forward      (forward),
    .stall        (stall)
`ifdef HAZ_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int          n_asserts = 0;
  int          n_fails   = 0;
  int          edges     = 0;
  int          ready_at [NR];
  logic [31:0] exp_stall_cnt = '0;

  // Reference model ---------------------------------------------------------
  function automatic logic model_stall();
    for (int i = 0; i < NS; i++) begin
      if (rs_ID_valid[i] && (ready_at[int'(rs_ID[i*AW +: AW])] > edges)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
    if (RegWrite_MEM && rd_MEM != 0 && rd_MEM == src) return 2'b10;
    if (RegWrite_WB && rd_WB != 0 && rd_WB == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) ready_at[r] = 0;
    exp_stall_cnt = '0;
  endfunction

  // Checking ---------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] r, input logic v);
    rs_ID[i*AW +: AW] = r;
    rs_ID_valid[i]    = v;
  endtask

  // One transaction: check combinational outputs mid-cycle, advance model,
  // clock, then check the statistics counter just after the edge.
  // want_stall < 0 means "model only", otherwise also checks a fixed value.
  task automatic cycle(input string tag, input int want_stall);
    logic s;
    #1;
    s = model_stall();
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    if (want_stall >= 0) chk({tag, ".stall_fixed"}, 32'(stall), 32'(want_stall));
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("%s.fwd%0d", tag, i), 32'(forward[2*i +: 2]),
          32'(model_fwd(rs_EX[i*AW +: AW])));
    end
    $display("%s: stall=%0b forward=%b", tag, stall, forward);
    if (rst_n) begin
      if (s && exp_stall_cnt != 32'hFFFF_FFFF) exp_stall_cnt++;
      if (flush) begin
        for (int r = 0; r < NR; r++) ready_at[r] = 0;
      end else if (issue_valid && issue_we && issue_rd != 0 && !s) begin
        ready_at[int'(issue_rd)] = edges + 1 + int'(issue_lat);
      end
    end
    @(posedge clk);
    edges++;
    #1;
`ifdef HAZ_STATS_EN
    chk({tag, ".stall_cycles"}, stall_cycles, exp_stall_cnt);
`endif
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rd, input logic [LW-1:0] lat);
    issue_valid = v;
    issue_we    = 1'b1;
    issue_rd    = rd;
    issue_lat   = lat;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; flush = 1'b0; rs_ID = '0; rs_ID_valid = '0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0; issue_lat = '0;
    rs_EX = '0; rd_MEM = '0; rd_WB = '0; RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0;

    // Reset state
    cycle("reset0", 0);
    cycle("reset1", 0);
    rst_n = 1'b1;

    // Forwarding: MEM priority over WB
    rd_MEM = 5; rd_WB = 5; RegWrite_MEM = 1; RegWrite_WB = 1;
    rs_EX[0 +: AW] = 5; rs_EX[AW +: AW] = 5;
    #1; chk("fwd_mem_prio", 32'(forward[1:0]), 32'(2'b10));
    cycle("fwd_prio", -1);
    // Register 0 never forwards
    rd_MEM = 0; RegWrite_MEM = 1; rd_WB = 3; RegWrite_WB = 0;
    rs_EX[AW +: AW] = 0;
    #1; chk("fwd_r0", 32'(forward[3:2]), 32'(2'b00));
    cycle("fwd_r0", -1);
    // WB path
    rd_MEM = 4; rd_WB = 6; RegWrite_WB = 1; rs_EX[0 +: AW] = 6; rs_EX[AW +: AW] = 4;
    cycle("fwd_wb", -1);

    // Four stalled cycles then async reset mid-countdown
    issue(1, 5, 7);
    cycle("iss5", 0);
    issue(0, 0, 0);
    set_src(0, 5, 1);
    for (int k = 0; k < 4; k++) cycle($sformatf("stall5_%0d", k), 1);
`ifdef HAZ_STATS_EN
    chk("stats_before_reset", stall_cycles, 32'd4);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_stall", 32'(stall), 32'd0);
`ifdef HAZ_STATS_EN
    chk("stats_after_reset", stall_cycles, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("post_reset", 0);
    set_src(0, 0, 0);

    // Issue rd=7 lat=2: two stall cycles
    issue(1, 7, 2);
    cycle("iss7", 0);
    issue(0, 0, 0);
    set_src(0, 7, 1);
    cycle("s7a", 1);
    cycle("s7b", 1);
    cycle("s7c", 0);

    // Unused source does not stall
    set_src(0, 0, 0);
    issue(1, 7, 3);
    cycle("iss7b", 0);
    issue(0, 0, 0);
    set_src(0, 7, 0);
    cycle("unused7", 0);

    // Flush clears entries and drops a same-cycle issue
    issue(1, 9, 3);
    cycle("iss9", 0);
    issue(0, 0, 0);
    set_src(0, 9, 1);
    cycle("s9", 1);
    set_src(0, 0, 0);
    flush = 1'b1;
    issue(1, 10, 4);
    cycle("flush", 0);
    flush = 1'b0;
    issue(0, 0, 0);
    set_src(0, 9, 1); set_src(1, 10, 1);
    cycle("post_flush", 0);

    // No self-stall on own destination
    set_src(1, 0, 0);
    set_src(0, 3, 1);
    issue(1, 3, 2);
    cycle("self3", 0);
    issue(0, 0, 0);
    cycle("after_self3", 1);
    set_src(0, 0, 0);
    cycle("drain", -1);
    cycle("drain2", -1);

    // Stalled issue is not recorded
    issue(1, 11, 3);
    cycle("iss11", 0);
    set_src(0, 11, 1);
    issue(1, 12, 5);
    cycle("blocked12", 1);
    issue(0, 0, 0);
    set_src(0, 12, 1);
    cycle("chk12", 0);
    set_src(0, 0, 0);

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      flush        = ($urandom_range(19) == 0);
      issue_valid  = $urandom_range(1);
      issue_we     = ($urandom_range(3) != 0);
      issue_rd     = AW'($urandom_range(7));
      issue_lat    = LW'($urandom_range(7));
      rs_ID_valid  = NS'($urandom_range(3));
      for (int i = 0; i < NS; i++) begin
        rs_ID[i*AW +: AW] = AW'($urandom_range(7));
        rs_EX[i*AW +: AW] = AW'($urandom_range(7));
      end
      rd_MEM       = AW'($urandom_range(7));
      rd_WB        = AW'($urandom_range(7));
      RegWrite_MEM = $urandom_range(1);
      RegWrite_WB  = $urandom_range(1);
      cycle($sformatf("rnd%0d", n), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2, giving the number of source operands per instruction.
REQ-002 The block SHALL have parameter REG_AW, default 5, giving the register address width (2**REG_AW registers).
REQ-003 The block SHALL have parameter LAT_W, default 3, giving the scoreboard countdown width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset; reset is asynchronous and active-low.
REQ-006 The block SHALL have port flush, input, 1, which clears pipeline-speculative scoreboard state.
REQ-007 The block SHALL have port rs_ID, input, NUM_SRC*REG_AW, the decode-stage source registers, with source i at bits [i*REG_AW +: REG_AW].
REQ-008 The block SHALL have port rs_ID_valid, input, NUM_SRC, the per-source "operand used" flags.
REQ-009 The block SHALL have ports issue_valid (1), issue_we (1), issue_rd (REG_AW) and issue_lat (LAT_W), all inputs, describing the decode-stage instruction and its result latency in cycles.
REQ-010 The block SHALL have port rs_EX, input, NUM_SRC*REG_AW, the EX-stage source registers, packed as rs_ID.
REQ-011 The block SHALL have ports rd_MEM, rd_WB (REG_AW) and RegWrite_MEM, RegWrite_WB (1), all inputs, describing the later-stage writebacks.
REQ-012 The block SHALL have port forward, output, 2*NUM_SRC, the per-source forward select, with source i at bits [2i+1:2i].
REQ-013 The block SHALL have port stall, output, 1, which holds the IF and ID stages and inserts a bubble into EX.

Function
REQ-014 Each forward field SHALL be combinational: 2'b10 when RegWrite_MEM && rd_MEM!=0 && rd_MEM==src; else 2'b01 when RegWrite_WB && rd_WB!=0 && rd_WB==src; else 2'b00. MEM SHALL take priority over WB.
REQ-015 The scoreboard SHALL hold one LAT_W-bit counter per register, cnt[r]; cnt[0] SHALL be constant 0.
REQ-016 stall SHALL be combinational: 1 iff some source i has rs_ID_valid[i]==1 and cnt[rs_ID[i]]!=0.
REQ-017 Each cycle, every nonzero cnt[r] SHALL decrement by 1, saturating at 0.
REQ-018 On an accepted issue (issue_valid && issue_we && issue_rd!=0 && !stall && !flush), cnt[issue_rd] SHALL load issue_lat; the load SHALL override a same-cycle decrement.
REQ-019 issue_lat==0 SHALL leave no entry (cnt stays 0); that result is covered by forwarding alone.
REQ-020 An issue SHALL NOT be recorded while stall==1.
REQ-021 On flush==1, all counters SHALL clear to 0 on the next edge, and flush SHALL take priority over issue.
REQ-022 A source equal to issue_rd of the same-cycle issuing instruction SHALL read the pre-update cnt (no self-stall).

Reset
REQ-023 While rst_n==0, all cnt SHALL be 0, so stall==0; forward SHALL depend only on its inputs.
REQ-024 If reset is asserted mid-countdown, the pending entries SHALL be lost and stall SHALL deassert immediately (asynchronously).

Configuration
REQ-025 With HAZ_STATS_EN defined, the block SHALL add output stall_cycles (32 bits), reset to 0, which increments each cycle stall==1 and saturates at 32'hFFFFFFFF.
REQ-026 With HAZ_STATS_EN undefined, the block SHALL have no stall_cycles port and no counter logic.

Verification
REQ-027 rd_MEM=5 and rd_WB=5, both RegWrite=1, rs_EX[0]=5: forward[1:0] SHALL be 2'b10.
REQ-028 rd_MEM=0, RegWrite_MEM=1, rs_EX[1]=0: forward[3:2] SHALL be 2'b00.
REQ-029 Issue rd=7 with lat=2, then rs_ID[0]=7 valid: stall SHALL be 1 for 2 cycles, then 0.
REQ-030 Source 7 with rs_ID_valid[0]=0 while cnt[7]=3: stall SHALL be 0.
REQ-031 cnt[9]=3, then assert flush: stall on source 9 SHALL be 0 in the next cycle; a same-cycle issue SHALL be dropped.
REQ-032 Under HAZ_STATS_EN, 4 stalled cycles then reset: stall_cycles SHALL read 4, then 0.
